// File: rtl/car_plant_model_if.sv
// Command/feedback bundle between the car control unit (master) and the
// vehicle plant model (slave).
interface car_plant_model_if;
  logic       accelerate_car;
  logic       unlock_doors;
  logic [7:0] lead_speed;
  logic       load_distance;
  logic [6:0] distance_in;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       tick;
  logic       doors_open;
  logic       collision;
  logic       door_fault;

  modport master (
    output accelerate_car, unlock_doors, lead_speed, load_distance, distance_in,
    input  car_speed, leading_distance, tick, doors_open, collision, door_fault
  );

  modport slave (
    input  accelerate_car, unlock_doors, lead_speed, load_distance, distance_in,
    output car_speed, leading_distance, tick, doors_open, collision, door_fault
  );
endinterface

// File: rtl/car_plant_model.sv
// Vehicle plant model: integrates speed and gap on a divided physics tick,
// runs the door actuator FSM and raises sticky collision / door-fault flags.
module car_plant_model #(
  parameter int         TICK_DIV      = 4,
  parameter logic [7:0] ACCEL_STEP    = 8'd4,
  parameter logic [7:0] DECEL_STEP    = 8'd8,
  parameter logic [7:0] MAX_SPEED     = 8'd200,
  parameter logic [6:0] INIT_DISTANCE = 7'd100,
  parameter int         DOOR_CYCLES   = 3
) (
  input logic              clk,
  input logic              rst,
  car_plant_model_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DOOR_CYCLES - 1);

  localparam logic [1:0] LOCKED    = 2'd0;
  localparam logic [1:0] UNLOCKING = 2'd1;
  localparam logic [1:0] OPEN      = 2'd2;
  localparam logic [1:0] CLOSING   = 2'd3;

  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          tick_q;
  logic [7:0]    speed_q;
  logic [6:0]    gap_q;
  logic          collision_q;
  logic [1:0]    door_state, door_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          doors_open_q;
  logic          door_fault_q;

  logic [8:0]        spd_up9;
  logic [7:0]        spd_acc, spd_dec, spd_new;
  logic [8:0]        lead_d, own_d;
  logic signed [8:0] gap9;
  logic              crash;

  assign tcnt_nxt = (tcnt == TLAST) ? '0 : tcnt + TW'(1);

  // Tick divider; tick_q is registered so it is high exactly while tcnt == TLAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt   <= tcnt_nxt;
      tick_q <= (tcnt_nxt == TLAST);
    end
  end

  // Next speed and next gap from the pre-update speed
  always_comb begin
    spd_up9 = {1'b0, speed_q} + {1'b0, ACCEL_STEP};
    spd_acc = (spd_up9 > {1'b0, MAX_SPEED}) ? MAX_SPEED : spd_up9[7:0];
    spd_dec = (speed_q >= DECEL_STEP) ? speed_q - DECEL_STEP : '0;
    spd_new = bus.accelerate_car ? spd_acc : spd_dec;
    lead_d  = {1'b0, bus.lead_speed} >> 3;
    own_d   = {1'b0, speed_q} >> 3;
    gap9    = $signed({2'b00, gap_q}) + $signed(lead_d) - $signed(own_d);
    crash   = (gap9 <= 9'sd0) && (speed_q != 8'd0);
  end

  // Physics state: a distance load pre-empts the tick gap update (and its crash check)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q     <= '0;
      gap_q       <= INIT_DISTANCE;
      collision_q <= 1'b0;
    end else begin
      if (tick_q) begin
        if (collision_q)
          speed_q <= '0;
        else if (crash && !bus.load_distance) begin
          speed_q     <= '0;
          collision_q <= 1'b1;
        end else
          speed_q <= spd_new;
      end
      if (bus.load_distance)
        gap_q <= bus.distance_in;
      else if (tick_q && !collision_q) begin
        if (gap9 > 9'sd127)
          gap_q <= 7'd127;
        else if (gap9 <= 9'sd0)
          gap_q <= '0;
        else
          gap_q <= gap9[6:0];
      end
    end
  end

  // Door FSM next state, evaluated every clock
  always_comb begin
    door_nxt = door_state;
    dcnt_nxt = dcnt;
    case (door_state)
      LOCKED: begin
        if (bus.unlock_doors && speed_q == 8'd0) begin
          door_nxt = UNLOCKING;
          dcnt_nxt = '0;
        end
      end
      UNLOCKING: begin
        if (!bus.unlock_doors || speed_q != 8'd0) begin
          door_nxt = LOCKED;
          dcnt_nxt = '0;
        end else if (dcnt == DLAST) begin
          door_nxt = OPEN;
          dcnt_nxt = '0;
        end else
          dcnt_nxt = dcnt + DW'(1);
      end
      OPEN: begin
        if (!bus.unlock_doors) begin
          door_nxt = CLOSING;
          dcnt_nxt = '0;
        end
      end
      default: begin
        if (bus.unlock_doors && speed_q == 8'd0) begin
          door_nxt = UNLOCKING;
          dcnt_nxt = '0;
        end else if (dcnt == DLAST) begin
          door_nxt = LOCKED;
          dcnt_nxt = '0;
        end else
          dcnt_nxt = dcnt + DW'(1);
      end
    endcase
  end

  // Door state, registered doors_open decode and sticky door fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_state   <= LOCKED;
      dcnt         <= '0;
      doors_open_q <= 1'b0;
      door_fault_q <= 1'b0;
    end else begin
      door_state   <= door_nxt;
      dcnt         <= dcnt_nxt;
      doors_open_q <= (door_nxt == OPEN) || (door_nxt == CLOSING);
      if (((door_state == OPEN) || (door_state == CLOSING)) && speed_q != 8'd0)
        door_fault_q <= 1'b1;
    end
  end

  assign bus.car_speed        = speed_q;
  assign bus.leading_distance = gap_q;
  assign bus.tick             = tick_q;
  assign bus.doors_open       = doors_open_q;
  assign bus.collision        = collision_q;
  assign bus.door_fault       = door_fault_q;

endmodule

// File: tb/tb_car_plant_model.sv
// Directed self-checking bench for car_plant_model (default parameters).
module tb_car_plant_model;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  car_plant_model_if bus();

  car_plant_model #(
    .TICK_DIV(4), .ACCEL_STEP(8'd4), .DECEL_STEP(8'd8), .MAX_SPEED(8'd200),
    .INIT_DISTANCE(7'd100), .DOOR_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance (at negedges) until the current cycle is a physics-update cycle
  task automatic wait_tick_cycle();
    int unsigned n = 0;
    while (bus.tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fails++;
      $error("FAIL tick_timeout: observed no tick in %0d cycles expected tick", n);
    end
  endtask

  // Return at the negedge right after the next physics update
  task automatic next_tick();
    wait_tick_cycle();
    @(negedge clk);
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    bus.accelerate_car = 1'b0;
    bus.unlock_doors   = 1'b0;
    bus.lead_speed     = 8'd255;
    bus.load_distance  = 1'b0;
    bus.distance_in    = 7'd0;

    // Reset values
    cycles(2);
    chk("rst_speed", 16'(bus.car_speed), 16'd0);
    chk("rst_gap", 16'(bus.leading_distance), 16'd100);
    chk("rst_tick", 16'(bus.tick), 16'd0);
    chk("rst_doors", 16'(bus.doors_open), 16'd0);
    chk("rst_coll", 16'(bus.collision), 16'd0);
    chk("rst_fault", 16'(bus.door_fault), 16'd0);
    rst = 1'b0;

    // Acceleration to saturation
    bus.accelerate_car = 1'b1;
    for (int unsigned n = 1; n <= 52; n++) begin
      next_tick();
      chk("accel_speed", 16'(bus.car_speed), (n * 4 > 200) ? 16'd200 : 16'(n * 4));
    end
    chk("gap_clamp_lead", 16'(bus.leading_distance), 16'd127);

    // Deceleration to zero and hold
    bus.accelerate_car = 1'b0;
    for (int unsigned n = 1; n <= 26; n++) begin
      next_tick();
      chk("decel_speed", 16'(bus.car_speed), (n * 8 >= 200) ? 16'd0 : 16'(200 - n * 8));
    end

    // Collision: speed 200, lead stopped, gap 30 -> 5 -> 0 with collision
    bus.accelerate_car = 1'b1;
    for (int unsigned n = 0; n < 50; n++) next_tick();
    chk("speed_200", 16'(bus.car_speed), 16'd200);
    bus.lead_speed    = 8'd0;
    bus.load_distance = 1'b1;
    bus.distance_in   = 7'd30;
    @(negedge clk);
    bus.load_distance = 1'b0;
    chk("load_30", 16'(bus.leading_distance), 16'd30);
    next_tick();
    chk("gap_5", 16'(bus.leading_distance), 16'd5);
    chk("speed_pre_crash", 16'(bus.car_speed), 16'd200);
    chk("no_coll_yet", 16'(bus.collision), 16'd0);
    next_tick();
    chk("crash_gap", 16'(bus.leading_distance), 16'd0);
    chk("crash_speed", 16'(bus.car_speed), 16'd0);
    chk("crash_coll", 16'(bus.collision), 16'd1);
    next_tick();
    chk("post_crash_speed", 16'(bus.car_speed), 16'd0);
    chk("coll_sticky", 16'(bus.collision), 16'd1);
    bus.load_distance = 1'b1;
    bus.distance_in   = 7'd40;
    @(negedge clk);
    bus.load_distance = 1'b0;
    chk("load_in_coll", 16'(bus.leading_distance), 16'd40);
    bus.accelerate_car = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("coll_cleared", 16'(bus.collision), 16'd0);
    rst = 1'b0;

    // Gap clamps at 127; zero gap at standstill is not a collision
    bus.lead_speed    = 8'd255;
    bus.load_distance = 1'b1;
    bus.distance_in   = 7'd120;
    @(negedge clk);
    bus.load_distance = 1'b0;
    next_tick();
    chk("clamp_127", 16'(bus.leading_distance), 16'd127);
    bus.lead_speed    = 8'd0;
    bus.load_distance = 1'b1;
    bus.distance_in   = 7'd0;
    @(negedge clk);
    bus.load_distance = 1'b0;
    next_tick();
    chk("zero_gap", 16'(bus.leading_distance), 16'd0);
    chk("zero_gap_no_coll", 16'(bus.collision), 16'd0);

    // Door open / close / reopen during CLOSING
    bus.lead_speed   = 8'd255;
    bus.unlock_doors = 1'b1;
    cycles(3);
    chk("open_c3", 16'(bus.doors_open), 16'd0);
    cycles(1);
    chk("open_c4", 16'(bus.doors_open), 16'd1);
    bus.unlock_doors = 1'b0;
    cycles(3);
    chk("close_c3", 16'(bus.doors_open), 16'd1);
    cycles(1);
    chk("close_c4", 16'(bus.doors_open), 16'd0);
    bus.unlock_doors = 1'b1;
    cycles(4);
    chk("reopen1", 16'(bus.doors_open), 16'd1);
    bus.unlock_doors = 1'b0;
    cycles(2);
    chk("closing_mid", 16'(bus.doors_open), 16'd1);
    bus.unlock_doors = 1'b1;
    cycles(1);
    chk("back_unlocking", 16'(bus.doors_open), 16'd0);
    cycles(3);
    chk("reopen2", 16'(bus.doors_open), 16'd1);

    // Door fault: drive off with doors open
    bus.accelerate_car = 1'b1;
    next_tick();
    chk("fault_speed", 16'(bus.car_speed), 16'd4);
    chk("fault_not_yet", 16'(bus.door_fault), 16'd0);
    @(negedge clk);
    chk("fault_set", 16'(bus.door_fault), 16'd1);
    bus.accelerate_car = 1'b0;
    next_tick();
    chk("fault_stop_speed", 16'(bus.car_speed), 16'd0);
    chk("fault_sticky", 16'(bus.door_fault), 16'd1);
    bus.unlock_doors = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("fault_cleared", 16'(bus.door_fault), 16'd0);
    rst = 1'b0;

    // Distance load on a tick cycle; speed still updates
    wait_tick_cycle();
    bus.load_distance  = 1'b1;
    bus.distance_in    = 7'd50;
    bus.accelerate_car = 1'b1;
    @(negedge clk);
    bus.load_distance  = 1'b0;
    bus.accelerate_car = 1'b0;
    chk("load_tick_gap", 16'(bus.leading_distance), 16'd50);
    chk("load_tick_speed", 16'(bus.car_speed), 16'd4);
    next_tick();
    chk("stop_again", 16'(bus.car_speed), 16'd0);

    // Reset in the middle of UNLOCKING
    bus.unlock_doors = 1'b1;
    cycles(2);
    chk("unlocking_closed", 16'(bus.doors_open), 16'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_speed", 16'(bus.car_speed), 16'd0);
    chk("mid_rst_gap", 16'(bus.leading_distance), 16'd100);
    chk("mid_rst_tick", 16'(bus.tick), 16'd0);
    chk("mid_rst_doors", 16'(bus.doors_open), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    chk("after_rst_c3", 16'(bus.doors_open), 16'd0);
    cycles(1);
    chk("after_rst_c4", 16'(bus.doors_open), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/car_plant_model.md
# car_plant_model

Closed-loop vehicle plant model that sits opposite the car control unit. It consumes the controller's `accelerate_car` and `unlock_doors` commands and produces the `car_speed` and `leading_distance` values the controller reads back. It integrates speed and gap on a divided physics tick, runs a door-actuator state machine, and raises sticky collision and door-safety flags. It is used in system-level benches and FPGA demos in place of a real vehicle.

## Interface
- `TICK_DIV`, default 4: clk cycles per physics update (≥2).
- `ACCEL_STEP`, default 8'd4: speed increment per tick while accelerating.
- `DECEL_STEP`, default 8'd8: speed decrement per tick while not accelerating.
- `MAX_SPEED`, default 8'd200: speed saturation ceiling.
- `INIT_DISTANCE`, default 7'd100: gap value after reset.
- `DOOR_CYCLES`, default 3: clk cycles for the door to open or close (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `accelerate_car`  in  1  command from controller.
- `unlock_doors`  in  1  command from controller.
- `lead_speed`  in  8  speed of the leading vehicle.
- `load_distance`  in  1  one-cycle strobe; forces the gap to `distance_in`.
- `distance_in`  in  7  gap value to load.
- `car_speed`  out  8  registered vehicle speed.
- `leading_distance`  out  7  registered gap to the lead vehicle.
- `tick`  out  1  registered one-cycle pulse, asserted on each physics update cycle.
- `doors_open`  out  1  high in OPEN and CLOSING.
- `collision`  out  1  sticky until rst.
- `door_fault`  out  1  sticky until rst.

## Operation
- Reset values: tick counter 0; `tick` 0; `car_speed` 0; `leading_distance` INIT_DISTANCE; door state LOCKED; door counter 0; `doors_open`, `collision`, `door_fault` all 0.
- Tick counter runs 0..TICK_DIV-1 and wraps. The physics update and `tick`=1 occur on the cycle the counter equals TICK_DIV-1.
- Speed update, using the pre-update speed S:
  - If `accelerate_car`=1: new speed = min(S+ACCEL_STEP, MAX_SPEED). Compute in 9 bits; no 8-bit wrap.
  - If `accelerate_car`=0: new speed = S≥DECEL_STEP ? S−DECEL_STEP : 0.
- Gap update, computed as 9-bit signed: D' = `leading_distance` + (`lead_speed`>>3) − (S>>3).
  - If D' > 127, clamp to 127.
  - If D' ≤ 0 and S ≠ 0: distance 0, speed 0, set `collision`.
  - If D' ≤ 0 and S = 0: distance 0, no collision.
- While `collision`=1: speed is held at 0 and the gap is frozen at each tick. `load_distance` still loads the gap. `collision` is not cleared.
- `load_distance` has priority over the tick gap update in the same cycle. Speed still updates on that cycle.
- Door FSM states: LOCKED, UNLOCKING, OPEN, CLOSING. Transitions are evaluated every clk cycle, not per tick.
  - LOCKED→UNLOCKING when `unlock_doors`=1 and `car_speed`=0. Counter is loaded with 0.
  - UNLOCKING: the counter increments each cycle. Go to OPEN when the counter reaches DOOR_CYCLES−1. Abort to LOCKED if `unlock_doors`=0 or `car_speed`≠0.
  - OPEN→CLOSING when `unlock_doors`=0. Counter is loaded with 0.
  - CLOSING: the counter increments. Go to LOCKED at DOOR_CYCLES−1. If `unlock_doors`=1 and `car_speed`=0, go back to UNLOCKING and restart the count.
- `door_fault` sets on any cycle where the state is OPEN or CLOSING and `car_speed`≠0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Speed and gap reflect the inputs sampled on the tick cycle, visible the following cycle. Latency from `accelerate_car` to a speed change is 1 to TICK_DIV cycles.
- `load_distance` takes effect on the next cycle, independent of tick phase.
- Door timing:
  - LOCKED→`doors_open`=1: DOOR_CYCLES+1 cycles after the first cycle with `unlock_doors`=1 and speed 0.
  - `doors_open` falls DOOR_CYCLES+1 cycles after `unlock_doors` deasserts.
- `collision` and `door_fault` assert the cycle after the triggering condition.
- Asserting rst mid-operation, including mid-door-transition, returns all state to reset values immediately.

## Test plan
- Reset, then `accelerate_car`=1 for 52 ticks -> speed 4, 8, … capped at 200 from tick 50 onward. Then `accelerate_car`=0 -> speed decreases by 8 per tick and holds at 0 after 25 ticks.
- Speed 200, `lead_speed`=0, gap loaded to 30 -> gap falls by 25 per tick. Next tick gives 5, the following one gives 0 with `collision`=1 and speed 0. Subsequent `accelerate_car`=1 leaves speed at 0.
- `lead_speed`=255, speed 0, gap 120 -> gap clamps at 127.
- Speed 0, `unlock_doors`=1 -> `doors_open`=1 exactly 4 cycles later. Deassert -> `doors_open`=0 after 4 cycles. Reassert during CLOSING -> returns to UNLOCKING, then OPEN.
- `doors_open`=1 with `accelerate_car`=1 -> speed 4 at the next tick and `door_fault`=1 one cycle later. Fault persists until rst.
- `load_distance` with `distance_in`=50 on a tick cycle -> gap 50, while speed still updates. rst asserted during UNLOCKING -> LOCKED with all outputs at reset values.
